tri_bus_arbiter: RTL and testbench
==================================

# tri_bus_arbiter

Parametrised, registered successor to the plain tri-state buffer: arbitrates up to NSRC sources for one shared tri-state data bus in the 8-bit processor datapath. A round-robin FSM grants one source at a time and drives that source's registered data onto the bus. It enforces a one-cycle high-Z turnaround between owners and a bounded hold time. This lets register file, ALU and memory interface share one bus without contention.

## Interface
- WIDTH, 8: bus and per-source data width.
- NSRC, 4: number of sources (2..8).
- MAX_HOLD, 4: cycles an owner may keep the bus while another source is requesting (≥1).
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  NSRC  per-source bus request, level-sensitive.
- data_in  in  NSRC*WIDTH  source i data in bits [i*WIDTH +: WIDTH].
- grant  out  NSRC  one-hot registered grant; all-zero when no owner.
- owner  out  clog2(NSRC) (min 1)  index of current owner; holds last owner when idle.
- bus  out (tri)  WIDTH  shared bus; driven only in DRIVE, otherwise all Z.
- bus_valid  out  1  high exactly when bus is driven.

## Operation
- States: IDLE, DRIVE, TURN. Reset → IDLE.
- Registers: state, owner, rr_ptr (last owner), hold_cnt, data_reg[WIDTH-1:0].
- Reset values: state IDLE, grant 0, owner 0, rr_ptr NSRC-1 (so source 0 wins first), hold_cnt 0, data_reg 0, bus_valid 0, bus Z.
- Winner selection: first asserted req scanning (rr_ptr+1) mod NSRC upward with wrap.
- IDLE: if any req → DRIVE with winner; owner=winner, rr_ptr=winner, grant one-hot, hold_cnt=1, data_reg=data_in[winner]. Else stay IDLE.
- DRIVE: bus=data_reg, bus_valid=1.
  - Owner keeps req, and either no other req or hold_cnt<MAX_HOLD → stay; data_reg reloads from owner's data_in each edge; hold_cnt increments, saturating at MAX_HOLD.
  - Owner drops req, or hold_cnt==MAX_HOLD with any other req asserted → TURN; grant=0, bus Z.
- TURN: exactly one cycle, bus Z, grant 0, bus_valid 0. Next edge: arbitrate as in IDLE (the previous owner is lowest priority via rr_ptr) → DRIVE, or → IDLE if no req.
- The same source may re-win after TURN only if no other source requests.
- grant, owner and bus_valid derive only from registered state; no combinational path from req to outputs.
- bus = bus_valid ? data_reg : all Z.

## Timing
- Grant latency: req sampled high at edge t with bus free (IDLE) → grant and valid bus from edge t; bus carries data_in sampled at edge t.
- Data latency in DRIVE: data_in at edge t appears on bus after edge t, held one cycle.
- Handoff: owner releases at edge t → TURN after t → new owner drives after t+1. There is always at least one Z cycle between owners; two sources never drive in the same cycle.
- Forced rotation: with contention, owner drives MAX_HOLD cycles, then 1 TURN cycle.
- Simultaneous requests from IDLE: round-robin order only; no fixed priority after the first grant.
- req deasserted by a non-owner before it wins: ignored; no grant.
- Async reset mid-DRIVE: bus Z and grant 0 immediately, without waiting for clk. First grant after release is evaluated at the first edge with reset low.

## Test plan
- Reset: assert reset mid-DRIVE (owner 2, bus 0xA5) → bus Z, grant 0, bus_valid 0 within the same cycle, before the next clk edge; after release, req=0001 → owner 0.
- Single source: req=0100, data_in[2]=0x3C → grant=0100 and bus=0x3C after next edge. Change data to 0x3D → bus 0x3D one edge later. Drop req → 1 TURN cycle (Z), then IDLE.
- All request from reset: req=1111 held → owners 0,1,2,3,0… each for 4 cycles (MAX_HOLD=4), with exactly one Z/bus_valid=0 cycle between each.
- Uncontended hold: req=0010 held 20 cycles → owner 1 for all 20; no TURN; hold_cnt saturates.
- Release then contend: owner 3 drops req while req=0011 → TURN, then owner 0 (wrap from rr_ptr=3), then owner 1.
- Contention check: bench monitors that bus never shows X and that grant is at most one-hot every cycle across 1000 random req/data cycles.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for one shared tri-state data bus. The granted source's data is
// registered and driven onto the bus, with a one-cycle high-Z turnaround between owners.
module tri_bus_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NSRC     = 4,
  parameter int MAX_HOLD = 4,
  localparam int OW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC-1:0]       req,
  input  logic [NSRC*WIDTH-1:0] data_in,
  output logic [NSRC-1:0]       grant,
  output logic [OW-1:0]         owner,
  output tri   [WIDTH-1:0]      bus,
  output logic                  bus_valid
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  state_e             state_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      rr_ptr_q;
  logic [HW-1:0]      hold_cnt_q;
  logic [WIDTH-1:0]   data_q;
  logic [NSRC-1:0]    grant_q;
  logic               valid_q;

  logic               win_found;
  logic [OW-1:0]      winner;
  logic [OW-1:0]      scan_idx;
  logic [NSRC-1:0]    winner_onehot;
  logic [WIDTH-1:0]   winner_data;
  logic [WIDTH-1:0]   owner_data;
  logic               owner_req;
  logic               other_req;
  logic               hold_open;

  // Scan starts just past the last owner, so the previous owner has lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win_found = 1'b0;
    winner    = rr_ptr_q;
    scan_idx  = rr_ptr_q;
    for (int k = 1; k <= NSRC; k++) begin
      scan_idx = OW'((int'(rr_ptr_q) + k) % NSRC);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        winner    = scan_idx;
      end
    end
  end

  always_comb begin
    winner_onehot = NSRC'(1) << winner;
    winner_data   = data_in[int'(winner)*WIDTH +: WIDTH];
    owner_data    = data_in[int'(owner_q)*WIDTH +: WIDTH];
    owner_req     = req[owner_q];
    other_req     = |(req & ~(NSRC'(1) << owner_q));
    hold_open     = (hold_cnt_q < HW'(MAX_HOLD));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= OW'(NSRC - 1);
      hold_cnt_q <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, TURN: begin
          if (win_found) begin
            state_q    <= DRIVE;
            owner_q    <= winner;
            rr_ptr_q   <= winner;
            grant_q    <= winner_onehot;
            hold_cnt_q <= HW'(1);
            data_q     <= winner_data;
            valid_q    <= 1'b1;
          end else begin
            state_q    <= IDLE;
          end
        end
        DRIVE: begin
          if (owner_req && (!other_req || hold_open)) begin
            data_q <= owner_data;
            if (hold_open) begin
              hold_cnt_q <= hold_cnt_q + HW'(1);
            end
          end else begin
            // Release for exactly one high-Z cycle before anyone else may drive.
            state_q <= TURN;
            grant_q <= '0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign bus_valid = valid_q;
  assign bus       = valid_q ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Randomised and directed stimulus for tri_bus_arbiter, checked by a scoreboard fed from
// an ownership-level reference model and drained by an independent monitor.
module tb_tri_bus_arbiter;

  localparam int WIDTH    = 8;
  localparam int NSRC     = 4;
  localparam int MAX_HOLD = 4;
  localparam int OW       = $clog2(NSRC);

  logic                  clk;
  logic                  reset;
  logic [NSRC-1:0]       req;
  logic [NSRC*WIDTH-1:0] data_in;
  logic [NSRC-1:0]       grant;
  logic [OW-1:0]         owner;
  wire  [WIDTH-1:0]      bus;
  logic                  bus_valid;

  tri_bus_arbiter #(
    .WIDTH    (WIDTH),
    .NSRC     (NSRC),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .data_in   (data_in),
    .grant     (grant),
    .owner     (owner),
    .bus       (bus),
    .bus_valid (bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              valid;
    logic [NSRC-1:0] grant;
    int              owner;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the bus (-1 = nobody), how long, and who held it last.
  int               m_cur;
  int               m_held;
  int               m_last;
  int               m_owner;
  logic [WIDTH-1:0] m_data;

  function automatic exp_t model_out();
    exp_t e;
    e.valid = (m_cur >= 0);
    e.grant = (m_cur >= 0) ? NSRC'(1) << m_cur : '0;
    e.owner = m_owner;
    e.data  = m_data;
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] src_data(input int i);
    return data_in[i*WIDTH +: WIDTH];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cur   = -1;
      m_held  = 0;
      m_last  = NSRC - 1;
      m_owner = 0;
      m_data  = '0;
      exp_q.delete();
      exp_q.push_back(model_out());
    end else begin
      if (m_cur >= 0) begin
        bit others;
        others = 1'b0;
        for (int i = 0; i < NSRC; i++)
          if (i != m_cur && req[i]) others = 1'b1;
        if (req[m_cur] && (!others || m_held < MAX_HOLD)) begin
          m_held = (m_held < MAX_HOLD) ? m_held + 1 : MAX_HOLD;
          m_data = src_data(m_cur);
        end else begin
          m_cur = -1;
        end
      end else begin
        for (int k = 1; k <= NSRC; k++) begin
          int i;
          i = (m_last + k) % NSRC;
          if (m_cur < 0 && req[i]) begin
            m_cur   = i;
            m_last  = i;
            m_owner = i;
            m_held  = 1;
            m_data  = src_data(i);
          end
        end
      end
      exp_q.push_back(model_out());
    end
  end

  // Monitor: compares DUT outputs against the oldest expectation on every falling edge.
  always @(negedge clk) begin
    exp_t e;
    check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("bus_valid", 32'(bus_valid), 32'(e.valid));
      check("grant", 32'(grant), 32'(e.grant));
      check("owner", 32'(owner), 32'(e.owner));
      if (e.valid) begin
        check("bus_known", 32'($isunknown(bus)), 32'd0);
        check("bus_data", 32'(bus), 32'(e.data));
      end
    end
  end

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    data_in[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset   = 1'b0;
    req     = '0;
    data_in = '0;
    #1 reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);

    // Single source: first grant straight from IDLE, then data follows one edge later.
    req = 4'b0100;
    set_data(2, 8'h3C);
    cycles(1);
    check("single_grant", 32'(grant), 32'h4);
    check("single_bus", 32'(bus), 32'h3C);
    set_data(2, 8'h3D);
    cycles(1);
    check("single_bus_update", 32'(bus), 32'h3D);
    req = '0;
    cycles(1);
    check("single_turn_valid", 32'(bus_valid), 32'd0);
    cycles(1);
    check("single_idle_valid", 32'(bus_valid), 32'd0);
    cycles(1);

    // Asynchronous reset while source 2 drives 0xA5.
    req = 4'b0100;
    set_data(2, 8'hA5);
    cycles(3);
    check("pre_reset_bus", 32'(bus), 32'hA5);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid", 32'(bus_valid), 32'd0);
    check("async_reset_grant", 32'(grant), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0001;
    set_data(0, 8'h11);
    cycles(1);
    check("post_reset_owner", 32'(owner), 32'd0);
    req = '0;
    cycles(3);

    // All sources requesting: forced rotation every MAX_HOLD cycles.
    for (int i = 0; i < NSRC; i++) set_data(i, 8'(8'h50 + i));
    req = 4'b1111;
    cycles(45);
    req = '0;
    cycles(3);

    // Uncontended hold: the single requester keeps the bus indefinitely.
    req = 4'b0010;
    cycles(20);
    req = '0;
    cycles(3);

    // Owner 3 releases while 0 and 1 request: wraps to 0, then 1.
    req = 4'b1000;
    cycles(3);
    req = 4'b0011;
    cycles(14);
    req = '0;
    cycles(3);

    // Random traffic with sticky request patterns.
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) req = NSRC'($urandom);
      data_in = (NSRC*WIDTH)'($urandom);
      cycles(1);
    end
    req = '0;
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
